latch_level_reader: RTL and testbench
=====================================

LATCH_LEVEL_READER -- requirements
Module: latch_level_reader

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the number of consecutive synchronized samples required to accept a level change; legal range 2..255.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the debounce counter; it SHALL be at least ceil(log2(STABLE_CYCLES)).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-005 The block SHALL have port D, input, 1 bit, the asynchronous level from a level-sensitive latch Q output; it may change at any time.
REQ-006 The block SHALL have port Q, output, 1 bit, the debounced and synchronized copy of D.
REQ-007 The block SHALL have port rise, output, 1 bit, a one-cycle pulse when Q changes from 0 to 1.
REQ-008 The block SHALL have port fall, output, 1 bit, a one-cycle pulse when Q changes from 1 to 0.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a candidate level change is being qualified.
REQ-010 The block SHALL have port edge_cnt, output, 8 bits, the count of accepted transitions (rise plus fall).

Function
REQ-011 D SHALL pass through a two-flop synchronizer (s1 <= D, s2 <= s1); only s2 feeds the rest of the logic.
REQ-012 The FSM SHALL have four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-013 In LOW with s2=1, the FSM SHALL go to WAIT_HIGH with cnt <= 1; with s2=0 it SHALL hold.
REQ-014 In WAIT_HIGH with s2=0, the FSM SHALL return to LOW with cnt <= 0, and rise SHALL NOT pulse.
REQ-015 In WAIT_HIGH with s2=1 and cnt == STABLE_CYCLES-1, the FSM SHALL go to HIGH, set Q <= 1 and rise <= 1, and set cnt <= 0; otherwise it SHALL increment cnt.
REQ-016 HIGH and WAIT_LOW SHALL mirror REQ-013..015 with s2 inverted, setting Q <= 0 and fall <= 1 on acceptance.
REQ-017 rise and fall SHALL be registered, high for exactly one clk cycle, and never asserted in the same cycle.
REQ-018 Acceptance latency SHALL be as follows: if D changes before edge 0 and stays stable, Q and the pulse SHALL update on edge STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges including edge 0.
REQ-019 A D pulse that yields fewer than STABLE_CYCLES consecutive s2 samples SHALL produce no change on Q, rise, fall or edge_cnt.
REQ-020 busy SHALL be decoded from the state register: 1 in WAIT_HIGH or WAIT_LOW, else 0, with no combinational path from D.
REQ-021 edge_cnt SHALL increment by 1 on the same edge that asserts rise or fall, wrapping 255 -> 0 without flag or stall.
REQ-022 Q, rise, fall and edge_cnt SHALL change only on the acceptance edge; no output depends combinationally on D or s1.

Reset
REQ-023 On rst_n=0, the block SHALL immediately, without waiting for clk, clear s1, s2, cnt, Q, rise, fall, busy and edge_cnt to 0 and put the state in LOW.
REQ-024 Reset asserted mid-qualification (WAIT_*) SHALL abandon the candidate; no pulse SHALL be emitted.
REQ-025 After rst_n deasserts with D=1 held, the block SHALL treat it as a normal 0->1 change, giving rise per REQ-018 with edge_cnt=1.
REQ-026 Reset deassertion SHALL be synchronized to clk by the system; the block SHALL add no deassertion logic of its own.

Verification (STABLE_CYCLES=4)
REQ-027 Reset then hold D=0 for 20 cycles -> Q=0, rise=fall=busy=0, edge_cnt=0 throughout.
REQ-028 D 0->1 before edge 0 and held -> busy high from edge 2, Q=1 and rise=1 for one cycle at edge 5, edge_cnt=1.
REQ-029 With Q=1, a D low glitch of 2 cycles -> busy pulses, Q stays 1, fall never asserts, edge_cnt unchanged.
REQ-030 256 accepted alternating transitions from reset -> edge_cnt wraps to 0, and rise/fall counts are each 128.
REQ-031 Assert rst_n=0 asynchronously between edges while in WAIT_HIGH -> all outputs 0 before the next clk edge, and no rise after release while D=0.
REQ-032 Release reset with D=1 held -> rise at the 6th edge after release, Q=1, edge_cnt=1.

Source files
------------

// File: rtl/latch_level_reader.sv
// Two-flop synchronizer followed by a four-state debounce FSM for an asynchronous latch
// level, producing a clean registered copy, edge pulses and a transition counter.
module latch_level_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       D,
    output logic       Q,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] edge_cnt
);

    typedef enum logic [1:0] {
        StLow      = 2'd0,
        StWaitHigh = 2'd1,
        StHigh     = 2'd2,
        StWaitLow  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [7:0]       edge_cnt_q, edge_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= D;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLow;
            cnt_q      <= '0;
            q_q        <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            edge_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        edge_cnt_d = edge_cnt_q;

        unique case (state_q)
            StLow: begin
                if (s2_q) begin
                    state_d = StWaitHigh;
                    cnt_d   = CNT_W'(1);
                end
            end
            StWaitHigh: begin
                if (!s2_q) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHigh: begin
                if (!s2_q) begin
                    state_d = StWaitLow;
                    cnt_d   = CNT_W'(1);
                end
            end
            StWaitLow: begin
                if (s2_q) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
            end
        endcase

        // Counter wraps naturally at 8 bits.
        if (rise_d || fall_d) begin
            edge_cnt_d = edge_cnt_q + 8'd1;
        end
    end

    assign Q        = q_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign busy     = (state_q == StWaitHigh) || (state_q == StWaitLow);
    assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_latch_level_reader.sv
// Scoreboard bench for latch_level_reader: a run-length model predicts every cycle's outputs,
// plus directed latency, glitch, wrap and asynchronous-reset scenarios.
module tb_latch_level_reader;

    localparam int unsigned STABLE = 4;

    logic       clk;
    logic       rst_n;
    logic       D;
    logic       Q;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] edge_cnt;

    latch_level_reader #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .D       (D),
        .Q       (Q),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy),
        .edge_cnt(edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       q;
        logic       rise;
        logic       fall;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: count consecutive synchronized samples that disagree with Q.
    logic       m_s1, m_s2, m_q;
    int         m_run;
    logic [7:0] m_cnt;

    int rise_seen, fall_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_s1  = 1'b0;
        m_s2  = 1'b0;
        m_q   = 1'b0;
        m_run = 0;
        m_cnt = 8'd0;
        exp_q.delete();
    endtask

    // Called at a negedge: drive D, predict the next posedge, compare, return at next negedge.
    task automatic step(input logic d);
        exp_t e;
        exp_t got;
        D      = d;
        e      = '0;
        if (m_s2 != m_q) begin
            m_run++;
            if (m_run == STABLE) begin
                m_q   = ~m_q;
                m_run = 0;
                m_cnt = m_cnt + 8'd1;
                if (m_q) e.rise = 1'b1;
                else     e.fall = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        m_s2   = m_s1;
        m_s1   = d;
        e.q    = m_q;
        e.busy = (m_run != 0);
        e.cnt  = m_cnt;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("q", Q, got.q);
        check("rise", rise, got.rise);
        check("fall", fall, got.fall);
        check("busy", busy, got.busy);
        check("edge_cnt", edge_cnt, got.cnt);
        if (rise) rise_seen++;
        if (fall) fall_seen++;
        if (rise && fall) check("rise_fall_excl", 1, 0);
        @(negedge clk);
    endtask

    task automatic hard_reset(input logic d);
        @(negedge clk);
        rst_n = 1'b0;
        D     = d;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rise_seen = 0;
        fall_seen = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        D     = 1'b0;
        model_reset();
        rise_seen = 0;
        fall_seen = 0;
        #3;
        check("rst_q", Q, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", edge_cnt, 0);

        // Quiet line after reset.
        hard_reset(1'b0);
        for (int i = 0; i < 20; i++) step(1'b0);

        // Rising acceptance latency: busy from edge 2, rise at edge 5.
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (i == 1) check("busy_pre", busy, 0);
            if (i == 2) check("busy_edge2", busy, 1);
            if (i == 4) check("rise_early", rise, 0);
            if (i == 5) begin
                check("rise_edge5", rise, 1);
                check("q_edge5", Q, 1);
                check("cnt_edge5", edge_cnt, 1);
            end
        end

        // Two-cycle low glitch while high: must be rejected.
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        check("glitch_q", Q, 1);
        check("glitch_cnt", edge_cnt, 1);
        check("glitch_fall", fall_seen, 0);

        // Glitch just one sample short of acceptance on a rising candidate.
        for (int i = 0; i < 10; i++) step(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);

        // 256 accepted transitions from reset: counter wraps to zero.
        hard_reset(1'b0);
        for (int t = 0; t < 256; t++) begin
            for (int i = 0; i < 7; i++) step((t % 2) == 0);
        end
        check("wrap_cnt", edge_cnt, 0);
        check("wrap_rise", rise_seen, 128);
        check("wrap_fall", fall_seen, 128);

        // Asynchronous reset while qualifying a rise.
        hard_reset(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1);
        check("pre_arst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_q", Q, 0);
        check("arst_rise", rise, 0);
        check("arst_cnt", edge_cnt, 0);
        D = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rise_seen = 0;
        fall_seen = 0;
        for (int i = 0; i < 12; i++) step(1'b0);
        check("arst_no_rise", rise_seen, 0);

        // Release with D held high: rise on the 6th edge after release.
        hard_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (i == 5) begin
                check("rel_rise", rise, 1);
                check("rel_q", Q, 1);
                check("rel_cnt", edge_cnt, 1);
            end
        end
        check("rel_rise_total", rise_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
